// File: rtl/txn_pkg.sv
// txn_pkg: shared types and constants for the transaction ledger.
//   status_e : result codes returned with every record
//   state_e  : validator FSM states
//   field offsets inside the 128-bit transfer record, default parameters
package txn_pkg;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_INSUF = 2'd1,
        ST_FULL  = 2'd2,
        ST_OVF   = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_ALLOC  = 3'd2,
        S_CHECK  = 3'd3,
        S_WR_SND = 3'd4,
        S_WR_RCV = 3'd5,
        S_RESP   = 3'd6
    } state_e;

    localparam int unsigned REC_W         = 128;
    localparam int unsigned BLK_START_BIT = 9;
    localparam int unsigned AMT_LSB       = 10;
    localparam int unsigned AMT_MSB       = 31;

    localparam int unsigned DEF_ID_W     = 48;
    localparam int unsigned DEF_AMT_W    = 22;
    localparam int unsigned DEF_BAL_W    = 24;
    localparam int unsigned DEF_DEPTH    = 16384;
    localparam int unsigned DEF_INIT_BAL = 100;

endpackage

// File: rtl/ledger_ram.sv
// ledger_ram: 1R1W ledger storage, synchronous read (data one cycle after
// re), no reset on contents.
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr       : read request
//   rdata          : read data, valid the cycle after re
module ledger_ram #(
    parameter int unsigned W     = 72,
    parameter int unsigned DEPTH = 16384
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/txn_ledger.sv
// txn_ledger: transfer validator with an on-chip balance ledger.
//   clk, rst                       : clock, async active-high reset
//   in_data/in_valid/in_ready      : 128-bit transfer record input
//   out_data/out_status/out_valid/out_ready : echoed record plus status code
//   entry_count                    : number of allocated ledger accounts
// One record is in flight at a time: IDLE accepts, SCAN searches the
// allocated entries linearly, ALLOC assigns tentative new slots, CHECK does
// the funds/overflow arithmetic, WR_SND/WR_RCV commit, RESP hands back.
module txn_ledger
    import txn_pkg::*;
#(
    parameter int unsigned ID_W     = DEF_ID_W,
    parameter int unsigned AMT_W    = DEF_AMT_W,
    parameter int unsigned BAL_W    = DEF_BAL_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned INIT_BAL = DEF_INIT_BAL
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REC_W-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [REC_W-1:0]           out_data,
    output logic [1:0]                 out_status,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] entry_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned EW = ID_W + BAL_W;

    localparam logic [BAL_W:0] BAL_MAX = {1'b0, {BAL_W{1'b1}}};

    state_e            state_q,     state_d;
    status_e           status_q,    status_d;
    logic [REC_W-1:0]  rec_q,       rec_d;
    logic [CW-1:0]     count_q,     count_d;
    logic [CW-1:0]     issue_q,     issue_d;
    logic              rd_vld_q,    rd_vld_d;
    logic [AW-1:0]     rd_idx_q,    rd_idx_d;
    logic              snd_found_q, snd_found_d;
    logic              rcv_found_q, rcv_found_d;
    logic [AW-1:0]     snd_idx_q,   snd_idx_d;
    logic [AW-1:0]     rcv_idx_q,   rcv_idx_d;
    logic [BAL_W-1:0]  snd_bal_q,   snd_bal_d;
    logic [BAL_W-1:0]  rcv_bal_q,   rcv_bal_d;
    logic [1:0]        need_q,      need_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q,  in_ready_d;

    logic              ram_we, ram_re;
    logic [AW-1:0]     ram_waddr, ram_raddr;
    logic [EW-1:0]     ram_wdata, ram_rdata;

    logic [ID_W-1:0]   snd_id, rcv_id, rd_id;
    logic [BAL_W-1:0]  rd_bal;
    logic [AMT_W-1:0]  amt;
    logic              self_xfer;
    logic              hit_snd, hit_rcv;
    logic              snd_new, rcv_new;
    logic [1:0]        need;
    logic [CW:0]       free_slots;
    logic [CW-1:0]     rcv_alloc;
    logic [CW-1:0]     cnt_eff;
    logic [BAL_W:0]    amt_x, snd_diff, rcv_sum;

    assign snd_id    = rec_q[REC_W-1 -: ID_W];
    assign rcv_id    = rec_q[REC_W-1-ID_W -: ID_W];
    assign amt       = rec_q[AMT_MSB -: AMT_W];
    assign self_xfer = (snd_id == rcv_id);
    assign rd_id     = ram_rdata[EW-1 -: ID_W];
    assign rd_bal    = ram_rdata[BAL_W-1:0];

    // Only the first match per side counts; later duplicates are ignored.
    assign hit_snd = rd_vld_q && !snd_found_q && (rd_id == snd_id);
    assign hit_rcv = rd_vld_q && !rcv_found_q && (rd_id == rcv_id);

    // A self-transfer occupies at most one entry, so the receiver never
    // asks for its own slot.
    assign snd_new    = !snd_found_q;
    assign rcv_new    = !rcv_found_q && !self_xfer;
    assign need       = {1'b0, snd_new} + {1'b0, rcv_new};
    assign free_slots = (CW+1)'(DEPTH) - {1'b0, count_q};
    assign rcv_alloc  = count_q + CW'(snd_new);

    assign amt_x    = (BAL_W+1)'(amt);
    assign snd_diff = {1'b0, snd_bal_q} - amt_x;
    assign rcv_sum  = {1'b0, rcv_bal_q} + amt_x;

    assign cnt_eff  = in_data[BLK_START_BIT] ? '0 : count_q;

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        rec_d       = rec_q;
        count_d     = count_q;
        issue_d     = issue_q;
        rd_vld_d    = 1'b0;
        rd_idx_d    = rd_idx_q;
        snd_found_d = snd_found_q;
        rcv_found_d = rcv_found_q;
        snd_idx_d   = snd_idx_q;
        rcv_idx_d   = rcv_idx_q;
        snd_bal_d   = snd_bal_q;
        rcv_bal_d   = rcv_bal_q;
        need_d      = need_q;
        out_valid_d = out_valid_q;
        ram_re      = 1'b0;
        ram_raddr   = issue_q[AW-1:0];
        ram_we      = 1'b0;
        ram_waddr   = snd_idx_q;
        ram_wdata   = {snd_id, snd_bal_q};

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    rec_d       = in_data;
                    status_d    = ST_OK;
                    snd_found_d = 1'b0;
                    rcv_found_d = 1'b0;
                    issue_d     = '0;
                    count_d     = cnt_eff;
                    state_d     = (cnt_eff == '0) ? S_ALLOC : S_SCAN;
                end
            end

            S_SCAN: begin
                if (issue_q < count_q) begin
                    ram_re   = 1'b1;
                    rd_vld_d = 1'b1;
                    rd_idx_d = issue_q[AW-1:0];
                    issue_d  = issue_q + CW'(1);
                end
                if (hit_snd) begin
                    snd_found_d = 1'b1;
                    snd_idx_d   = rd_idx_q;
                    snd_bal_d   = rd_bal;
                end
                if (hit_rcv) begin
                    rcv_found_d = 1'b1;
                    rcv_idx_d   = rd_idx_q;
                    rcv_bal_d   = rd_bal;
                end
                // issue_q == count_q means the compare happening now is the
                // one for the last allocated entry.
                if ((snd_found_d && rcv_found_d) || (issue_q == count_q)) begin
                    rd_vld_d = 1'b0;
                    state_d  = S_ALLOC;
                end
            end

            S_ALLOC: begin
                need_d = '0;
                if ((CW+1)'(need) > free_slots) begin
                    status_d = ST_FULL;
                end else begin
                    need_d = need;
                    if (snd_new) begin
                        snd_idx_d = count_q[AW-1:0];
                        snd_bal_d = BAL_W'(INIT_BAL);
                    end
                    if (self_xfer) begin
                        rcv_idx_d = snd_idx_d;
                        rcv_bal_d = snd_bal_d;
                    end else if (rcv_new) begin
                        rcv_idx_d = rcv_alloc[AW-1:0];
                        rcv_bal_d = BAL_W'(INIT_BAL);
                    end
                end
                state_d = S_CHECK;
            end

            S_CHECK: begin
                if (status_q == ST_OK) begin
                    if ({1'b0, snd_bal_q} < amt_x) begin
                        status_d = ST_INSUF;
                    end else if (!self_xfer && (rcv_sum > BAL_MAX)) begin
                        status_d = ST_OVF;
                    end else if (!self_xfer) begin
                        snd_bal_d = snd_diff[BAL_W-1:0];
                        rcv_bal_d = rcv_sum[BAL_W-1:0];
                    end
                end
                state_d = S_WR_SND;
            end

            // Rejections still pass through this slot with the write
            // suppressed, so they share the self-transfer response latency.
            S_WR_SND: begin
                if (status_q == ST_OK) begin
                    ram_we    = 1'b1;
                    ram_waddr = snd_idx_q;
                    ram_wdata = {snd_id, snd_bal_q};
                    if (self_xfer) begin
                        count_d     = count_q + CW'(need_q);
                        out_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_WR_RCV;
                    end
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end

            S_WR_RCV: begin
                ram_we      = 1'b1;
                ram_waddr   = rcv_idx_q;
                ram_wdata   = {rcv_id, rcv_bal_q};
                count_d     = count_q + CW'(need_q);
                out_valid_d = 1'b1;
                state_d     = S_RESP;
            end

            S_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            status_q    <= ST_OK;
            rec_q       <= '0;
            count_q     <= '0;
            issue_q     <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            snd_found_q <= 1'b0;
            rcv_found_q <= 1'b0;
            snd_idx_q   <= '0;
            rcv_idx_q   <= '0;
            snd_bal_q   <= '0;
            rcv_bal_q   <= '0;
            need_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            rec_q       <= rec_d;
            count_q     <= count_d;
            issue_q     <= issue_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            snd_found_q <= snd_found_d;
            rcv_found_q <= rcv_found_d;
            snd_idx_q   <= snd_idx_d;
            rcv_idx_q   <= rcv_idx_d;
            snd_bal_q   <= snd_bal_d;
            rcv_bal_q   <= rcv_bal_d;
            need_q      <= need_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    ledger_ram #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = rec_q;
    assign out_status  = status_q;
    assign entry_count = count_q;

endmodule

// File: tb/tb_txn_ledger.sv
module tb_txn_ledger;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         sel = 1'b0;

    // Instance A: default parameters. Instance B: BAL_W=8, INIT_BAL=200, DEPTH=4.
    logic         iv_a, iv_b, ir_a, ir_b, ov_a, ov_b;
    logic [127:0] od_a, od_b;
    logic [1:0]   st_a, st_b;
    logic [14:0]  cnt_a;
    logic [2:0]   cnt_b;

    assign iv_a = in_valid & ~sel;
    assign iv_b = in_valid & sel;

    txn_ledger u_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv_a), .in_ready(ir_a),
        .out_data(od_a), .out_status(st_a), .out_valid(ov_a), .out_ready(out_ready),
        .entry_count(cnt_a)
    );

    txn_ledger #(.ID_W(48), .AMT_W(8), .BAL_W(8), .DEPTH(4), .INIT_BAL(200)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv_b), .in_ready(ir_b),
        .out_data(od_b), .out_status(st_b), .out_valid(ov_b), .out_ready(out_ready),
        .entry_count(cnt_b)
    );

    always #5 clk = ~clk;

    logic         obs_ir, obs_ov;
    logic [1:0]   obs_st;
    logic [127:0] obs_od;
    int           obs_cnt;
    assign obs_ir  = sel ? ir_b : ir_a;
    assign obs_ov  = sel ? ov_b : ov_a;
    assign obs_st  = sel ? st_b : st_a;
    assign obs_od  = sel ? od_b : od_a;
    assign obs_cnt = sel ? int'(cnt_b) : int'(cnt_a);

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sel;
        logic        blk;
        logic [47:0] snd;
        logic [47:0] rcv;
        int unsigned amt;
        logic [1:0]  st;
        int          cnt;
        int          lat;
    } vec_t;

    localparam logic [47:0] ID_A = 48'hA000_0000_0001;
    localparam logic [47:0] ID_B = 48'hB000_0000_0002;
    localparam logic [47:0] ID_C = 48'hC000_0000_0003;
    localparam logic [47:0] ID_D = 48'hD000_0000_0004;
    localparam logic [47:0] ID_E = 48'hE000_0000_0005;
    localparam logic [47:0] ID_F = 48'hF000_0000_0006;
    localparam logic [47:0] ID_P = 48'h1111_0000_0011;
    localparam logic [47:0] ID_Q = 48'h2222_0000_0022;
    localparam logic [47:0] ID_R = 48'h3333_0000_0033;
    localparam logic [47:0] ID_S = 48'h4444_0000_0044;
    localparam logic [47:0] ID_T = 48'h5555_0000_0055;
    localparam logic [47:0] ID_U = 48'h6666_0000_0066;
    localparam logic [47:0] ID_X = 48'h7777_0000_0077;
    localparam logic [47:0] ID_Y = 48'h8888_0000_0088;

    localparam logic [1:0] OK = 2'd0, INS = 2'd1, FUL = 2'd2, OVF = 2'd3;

    vec_t vecs[17];

    function automatic vec_t mkv(logic s, logic b, logic [47:0] sn, logic [47:0] rc,
                                 int unsigned a, logic [1:0] st, int c, int l);
        vec_t v;
        v.sel = s; v.blk = b; v.snd = sn; v.rcv = rc; v.amt = a;
        v.st = st; v.cnt = c; v.lat = l;
        return v;
    endfunction

    // Amount field is [31:10] for instance A (AMT_W=22), [31:24] for B (AMT_W=8).
    function automatic logic [127:0] mk_rec(logic s, logic b, logic [47:0] sn,
                                            logic [47:0] rc, int unsigned a);
        logic [31:0] lo;
        logic [31:0] av;
        av = a;
        lo = 32'h0000_0155;
        lo[9] = b;
        if (s) lo[31:24] = av[7:0];
        else   lo[31:10] = av[21:0];
        return {sn, rc, lo};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Latency is counted in cycles: cycle 0 is the cycle in which the
    // record is taken (in_valid && in_ready), cycle L the first with out_valid.
    task automatic run_txn(input logic [127:0] rec, output logic [1:0] st, output int cnt,
                           output int lat, output logic [127:0] od, output bit ok);
        int guard;
        ok = 1'b1; st = '0; cnt = 0; lat = 0; od = '0;
        in_data = rec;
        in_valid = 1'b1;
        guard = 0;
        while (!obs_ir && guard < 50) begin @(negedge clk); guard++; end
        if (!obs_ir) begin ok = 1'b0; in_valid = 1'b0; return; end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!obs_ov && lat < 200) begin @(negedge clk); lat++; end
        if (!obs_ov) begin ok = 1'b0; return; end
        st = obs_st; od = obs_od; cnt = obs_cnt;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic txn_check(input string nm, input vec_t v);
        logic [1:0]   st;
        logic [127:0] od, rec;
        int           cnt, lat;
        bit           ok;
        sel = v.sel;
        rec = mk_rec(v.sel, v.blk, v.snd, v.rcv, v.amt);
        run_txn(rec, st, cnt, lat, od, ok);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s timeout: no handshake within bound", nm);
            return;
        end
        chk({nm, " status"}, 128'(st), 128'(v.st));
        chk({nm, " count"}, 128'(cnt), 128'(v.cnt));
        chk({nm, " latency"}, 128'(lat), 128'(v.lat));
        chk({nm, " data"}, od, rec);
    endtask

    initial begin
        logic [127:0] rec, hold_od;
        logic [1:0]   hold_st;
        int           guard;

        // Instance A, default parameters, INIT_BAL=100.
        vecs[0]  = mkv(0, 1, ID_A, ID_B,  30, OK,  2,  5); // A=70 B=130
        vecs[1]  = mkv(0, 0, ID_B, ID_A, 130, OK,  2,  8); // B=0 A=200
        vecs[2]  = mkv(0, 0, ID_E, ID_C, 101, INS, 2,  7); // E new: 100<101
        vecs[3]  = mkv(0, 0, ID_E, ID_C, 100, OK,  4,  8); // E,C allocated only now
        vecs[4]  = mkv(0, 0, ID_D, ID_D,  50, OK,  5,  9); // self, D=100
        vecs[5]  = mkv(0, 0, ID_D, ID_A, 100, OK,  5, 11); // D still 100
        vecs[6]  = mkv(0, 0, ID_D, ID_A,   1, INS, 5, 10); // D=0
        vecs[7]  = mkv(0, 0, ID_B, ID_C,   0, OK,  5, 10); // zero amount, B=0
        vecs[8]  = mkv(0, 1, ID_A, ID_A,   0, OK,  1,  4); // block_start clears table
        // Instance B: BAL_W=8, INIT_BAL=200, DEPTH=4.
        vecs[9]  = mkv(1, 1, ID_X, ID_Y, 100, OVF, 0,  4); // 300 > 255
        vecs[10] = mkv(1, 0, ID_P, ID_Q,  10, OK,  2,  5); // P=190 Q=210
        vecs[11] = mkv(1, 0, ID_R, ID_P,   0, OK,  3,  8); // R=200
        vecs[12] = mkv(1, 0, ID_S, ID_T,   5, FUL, 3,  8); // needs 2, 1 free
        vecs[13] = mkv(1, 0, ID_P, ID_S,   5, OK,  4,  9); // P=185 S=205
        vecs[14] = mkv(1, 0, ID_Q, ID_R, 200, OVF, 4,  8); // 400 > 255
        vecs[15] = mkv(1, 0, ID_S, ID_Q,   0, OK,  4, 10);
        vecs[16] = mkv(1, 0, ID_U, ID_P,   1, FUL, 4,  9); // table full

        // Reset state.
        @(negedge clk);
        chk("reset in_ready", 128'(ir_a), 128'(0));
        chk("reset out_valid", 128'(ov_a), 128'(0));
        chk("reset count", 128'(cnt_a), 128'(0));
        chk("reset status", 128'(st_a), 128'(0));
        chk("reset data", od_a, 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after release", 128'(ir_a), 128'(1));

        for (int i = 0; i < 17; i++) begin
            txn_check($sformatf("row%0d", i), vecs[i]);
        end

        // Hold out_ready low for 10 cycles: outputs frozen, no new accept.
        sel = 1'b0;
        rec = mk_rec(0, 0, ID_A, ID_F, 10);
        in_data = rec;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!ov_a && guard < 100) begin @(negedge clk); guard++; end
        if (!ov_a) begin
            checks++; errors++;
            $display("FAIL hold timeout: out_valid never rose");
        end else begin
            hold_od = od_a;
            hold_st = st_a;
            chk("hold data", hold_od, rec);
            chk("hold status", 128'(hold_st), 128'(OK));
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                chk($sformatf("hold c%0d", c),
                    {ov_a, ir_a, st_a, od_a},
                    {1'b1, 1'b0, hold_st, hold_od});
            end
            chk("hold count", 128'(cnt_a), 128'(2));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk("post handshake ready", 128'({ov_a, ir_a}), 128'(2'b01));
        end

        // Reset asserted during SCAN (count 2 forces a scan).
        in_data = mk_rec(0, 0, ID_F, ID_A, 5);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid-scan reset", 128'({ov_a, ir_a, cnt_a}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after mid-scan reset", 128'({ov_a, ir_a, cnt_a}), 128'({1'b0, 1'b1, 15'd0}));
        txn_check("after reset", mkv(0, 0, ID_A, ID_B, 30, OK, 2, 5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/txn_ledger.md
# txn_ledger

Parametrised transaction validator with a balance ledger and full ready/valid handshaking on both sides. It accepts 128-bit transfer records, looks up or allocates sender and receiver accounts in an on-chip ledger RAM, and checks funds, capacity and balance overflow. It commits accepted transfers and returns every record with a status code. It sits between the transaction deframer and the downstream result packer, and replaces the fixed-size, non-backpressured validator.

## Interface
- `ID_W`, 48: account ID width.
- `AMT_W`, 22: transfer amount width.
- `BAL_W`, 24: stored balance width; must satisfy `BAL_W >= AMT_W`.
- `DEPTH`, 16384: number of ledger entries; power of two, at least 4.
- `INIT_BAL`, 100: opening balance of a newly allocated account.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  128  record:
  - `[127:128-ID_W]` sender.
  - next `ID_W` bits receiver.
  - `[31:32-AMT_W]` amount.
  - `[9]` block_start.
- `in_valid`  in  1  record present.
- `in_ready`  out  1  block can take a record.
- `out_data`  out  128  copy of the accepted `in_data`.
- `out_status`  out  2  result code:
  - 0 OK.
  - 1 INSUFFICIENT.
  - 2 FULL.
  - 3 OVERFLOW.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `entry_count`  out  $clog2(DEPTH+1)  allocated accounts.

## Operation
- The FSM states are IDLE, SCAN, ALLOC, CHECK, WR_SND, WR_RCV and RESP.
- **IDLE**
  - `in_ready`=1; a transfer is accepted when `in_valid && in_ready`.
  - On accept, latch the record, clear the found flags and go to SCAN.
  - If block_start=1, `entry_count` is cleared to 0 first, so the table is treated as empty for this record.
- **SCAN**
  - Issue RAM read addresses 0,1,… one per cycle; compare the returned ID against sender and receiver one cycle later.
  - The first match for each side latches that side's index and balance.
  - Stop when both sides are found, or when all `entry_count` addresses have been issued and their data compared.
  - With count 0 the block skips straight to ALLOC.
- **ALLOC**
  - Compute the number of new entries needed: 0, 1 or 2. A self-transfer (sender==receiver) needs at most 1.
  - If the needed entries exceed `DEPTH - entry_count`, status is FULL.
  - Otherwise assign new indices in order, sender first, starting at `entry_count`, with balance `INIT_BAL`. These are tentative; the count is not yet updated.
- **CHECK**, evaluated in this order:
  - If sender balance < amount, status is INSUFFICIENT.
  - Else if the receiver is not the sender and receiver balance + amount > 2^BAL_W−1, status is OVERFLOW.
  - Else status is OK.
  - Arithmetic is done at `BAL_W+1` bits.
  - Amount 0 is legal and gives OK.
- **WR_SND / WR_RCV** (OK status only)
  - Write `{id, new_balance}` for the sender, then for the receiver.
  - A self-transfer writes once with the balance unchanged, and WR_RCV is skipped.
  - `entry_count` increases by the number of newly allocated entries in WR_RCV, or in WR_SND for a self-transfer.
- **Rejections**: any non-OK status skips the writes. There is no allocation, no count change and no RAM write.
- **RESP**
  - `out_valid`=1 with `out_data` and `out_status` held stable until `out_ready`.
  - On the handshake cycle, return to IDLE.
- **Reset**, at any point:
  - State goes to IDLE; `entry_count`=0, `out_valid`=0, `out_status`=0, `out_data`=0.
  - `in_ready` is 0 while `rst` is high and 1 on the first edge after release.
  - RAM contents are not reset; they are unreachable because the count is 0.
  - An in-flight record is dropped; no partial write is guaranteed beyond any edge that has already completed.

## Timing
- The RAM has 1-cycle synchronous read and 1 write port; a read and a write never occur in the same cycle.
- Let K be the number of addresses issued in SCAN:
  - K = `entry_count` when the search is not satisfied early.
  - Otherwise K = index of the later hit + 1.
- SCAN occupies K+1 cycles when K>0, and 0 cycles when K=0.
- Latency from accept edge to `out_valid` rising:
  - OK non-self-transfer: 5 + scan cycles.
  - Rejected or self-transfer: 4 + scan cycles.
- `in_ready` is low from the accept edge until RESP completes, so throughput is one record in flight.
- Back-to-back: a new record can be accepted on the cycle after the RESP handshake.
- `out_valid` can be held indefinitely by the consumer; `out_data` and `out_status` must not change while it is held.

## Structure
- Package `txn_pkg` holds:
  - Status enum (`ST_OK`, `ST_INSUF`, `ST_FULL`, `ST_OVF`).
  - FSM state enum.
  - Field offset constants (block_start bit 9, amount LSB 10).
  - Default parameter constants.
- Sub-module `ledger_ram`: parametrised width (`ID_W+BAL_W`) and depth, 1R1W, synchronous read, no reset.
- The top level holds the FSM, the search/compare logic and the arithmetic.

## Test plan
- Fresh reset; record A→B amount 30 with block_start=1:
  - OK, count 2.
  - A=70 and B=130 are confirmed by a follow-up B→A amount 130, which returns OK.
- A→C amount 101 with A=100 new: INSUFFICIENT, count unchanged, no RAM write.
- `BAL_W`=8, `INIT_BAL`=200; two new IDs, transfer X→Y of 100: OVERFLOW (300 > 255), count stays 0.
- `DEPTH`=4 with 3 entries allocated; transfer between two new IDs: FULL. A transfer between one known ID and one new ID: OK, count 4.
- Self-transfer D→D amount 50 with D new: OK, count +1, one RAM write, D balance 100.
- Hold `out_ready`=0 for 10 cycles: outputs stable, `in_ready`=0. Assert `rst` mid-SCAN: `out_valid`=0, count 0, `in_ready`=1 after release.
